// File: rtl/rgb_timing_gen.sv
// Runtime-reconfigurable parallel-RGB timing generator with a pixel-request channel
// that leads rgb_de by PREFETCH cycles; timing updates land on frame boundaries.
module rgb_timing_gen #(
    parameter int unsigned CNT_W        = 12,
    parameter int unsigned XY_W         = 11,
    parameter int unsigned PREFETCH     = 2,
    parameter bit          HS_POL       = 1'b0,
    parameter bit          VS_POL       = 1'b0,
    parameter int unsigned DEF_H_ACTIVE = 480,
    parameter int unsigned DEF_H_FP     = 2,
    parameter int unsigned DEF_H_SYNC   = 41,
    parameter int unsigned DEF_H_BP     = 2,
    parameter int unsigned DEF_V_ACTIVE = 272,
    parameter int unsigned DEF_V_FP     = 2,
    parameter int unsigned DEF_V_SYNC   = 10,
    parameter int unsigned DEF_V_BP     = 2
) (
    input  logic             rgb_clk,
    input  logic             rgb_rst_n,
    input  logic             en,
    input  logic             cfg_wr,
    input  logic [CNT_W-1:0] cfg_h_active,
    input  logic [CNT_W-1:0] cfg_h_fp,
    input  logic [CNT_W-1:0] cfg_h_sync,
    input  logic [CNT_W-1:0] cfg_h_bp,
    input  logic [CNT_W-1:0] cfg_v_active,
    input  logic [CNT_W-1:0] cfg_v_fp,
    input  logic [CNT_W-1:0] cfg_v_sync,
    input  logic [CNT_W-1:0] cfg_v_bp,
    output logic             cfg_pending,
    output logic             cfg_err,
    output logic             req,
    output logic [XY_W-1:0]  req_x,
    output logic [XY_W-1:0]  req_y,
    output logic             rgb_hs,
    output logic             rgb_vs,
    output logic             rgb_de,
    output logic [XY_W-1:0]  rgb_x,
    output logic [XY_W-1:0]  rgb_y,
    output logic             frame_start,
    output logic             line_start
);

    localparam int unsigned SUM_W = CNT_W + 2;
    localparam int unsigned TAP_W = 5 + 2 * XY_W;
    localparam logic [SUM_W-1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] h_active, h_fp, h_sync, h_bp;
    logic [CNT_W-1:0] v_active, v_fp, v_sync, v_bp;
    logic [CNT_W-1:0] sh_h_active, sh_h_fp, sh_h_sync, sh_h_bp;
    logic [CNT_W-1:0] sh_v_active, sh_v_fp, sh_v_sync, sh_v_bp;
    logic [CNT_W-1:0] h_cnt, v_cnt;

    logic [SUM_W-1:0] h_sum_c, v_sum_c;
    logic             cfg_ok_c;
    logic [CNT_W-1:0] h_last_c, v_last_c, h_start_c, v_start_c, h_stop_c, v_stop_c;
    logic             frame_end_c, apply_c, in_act_c;

    // Sums are widened by two bits so an overflowing write can be detected
    assign h_sum_c  = SUM_W'(cfg_h_active) + SUM_W'(cfg_h_fp) + SUM_W'(cfg_h_sync) + SUM_W'(cfg_h_bp);
    assign v_sum_c  = SUM_W'(cfg_v_active) + SUM_W'(cfg_v_fp) + SUM_W'(cfg_v_sync) + SUM_W'(cfg_v_bp);
    assign cfg_ok_c = (|cfg_h_active) && (|cfg_h_sync) && (|cfg_v_active) && (|cfg_v_sync)
                      && (h_sum_c <= CNT_MAX) && (v_sum_c <= CNT_MAX);

    assign h_last_c    = h_active + h_fp + h_sync + h_bp - CNT_W'(1);
    assign v_last_c    = v_active + v_fp + v_sync + v_bp - CNT_W'(1);
    assign h_start_c   = h_sync + h_bp;
    assign v_start_c   = v_sync + v_bp;
    assign h_stop_c    = h_start_c + h_active;
    assign v_stop_c    = v_start_c + v_active;
    assign frame_end_c = (h_cnt == h_last_c) && (v_cnt == v_last_c);
    assign apply_c     = cfg_pending && (!en || frame_end_c);
    assign in_act_c    = en && (h_cnt >= h_start_c) && (h_cnt < h_stop_c)
                         && (v_cnt >= v_start_c) && (v_cnt < v_stop_c);

    // Shadow capture and frame-boundary apply; a same-cycle write lands after the apply
    always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
        if (!rgb_rst_n) begin
            h_active    <= CNT_W'(DEF_H_ACTIVE);
            h_fp        <= CNT_W'(DEF_H_FP);
            h_sync      <= CNT_W'(DEF_H_SYNC);
            h_bp        <= CNT_W'(DEF_H_BP);
            v_active    <= CNT_W'(DEF_V_ACTIVE);
            v_fp        <= CNT_W'(DEF_V_FP);
            v_sync      <= CNT_W'(DEF_V_SYNC);
            v_bp        <= CNT_W'(DEF_V_BP);
            sh_h_active <= '0;
            sh_h_fp     <= '0;
            sh_h_sync   <= '0;
            sh_h_bp     <= '0;
            sh_v_active <= '0;
            sh_v_fp     <= '0;
            sh_v_sync   <= '0;
            sh_v_bp     <= '0;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= cfg_wr && !cfg_ok_c;
            if (apply_c) begin
                h_active    <= sh_h_active;
                h_fp        <= sh_h_fp;
                h_sync      <= sh_h_sync;
                h_bp        <= sh_h_bp;
                v_active    <= sh_v_active;
                v_fp        <= sh_v_fp;
                v_sync      <= sh_v_sync;
                v_bp        <= sh_v_bp;
                cfg_pending <= 1'b0;
            end
            if (cfg_wr && cfg_ok_c) begin
                sh_h_active <= cfg_h_active;
                sh_h_fp     <= cfg_h_fp;
                sh_h_sync   <= cfg_h_sync;
                sh_h_bp     <= cfg_h_bp;
                sh_v_active <= cfg_v_active;
                sh_v_fp     <= cfg_v_fp;
                sh_v_sync   <= cfg_v_sync;
                sh_v_bp     <= cfg_v_bp;
                cfg_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
        if (!rgb_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == h_last_c) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == v_last_c) ? '0 : v_cnt + CNT_W'(1);
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    logic s1_hs, s1_vs, s1_fs, s1_ls;

    // Stage 1: request channel and sync/strobe decode
    always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
        if (!rgb_rst_n) begin
            req   <= 1'b0;
            req_x <= '0;
            req_y <= '0;
            s1_hs <= 1'b0;
            s1_vs <= 1'b0;
            s1_fs <= 1'b0;
            s1_ls <= 1'b0;
        end else begin
            req   <= in_act_c;
            req_x <= in_act_c ? XY_W'(h_cnt - h_start_c) : '0;
            req_y <= in_act_c ? XY_W'(v_cnt - v_start_c) : '0;
            s1_hs <= en && (h_cnt < h_sync);
            s1_vs <= en && (v_cnt < v_sync);
            s1_fs <= en && (h_cnt == '0) && (v_cnt == '0);
            s1_ls <= en && (h_cnt == '0);
        end
    end

    logic [TAP_W-1:0] s1_vec, out_vec;
    logic             out_hs, out_vs;

    assign s1_vec = {s1_hs, s1_vs, req, s1_fs, s1_ls, req_x, req_y};

    // Stage 2: PREFETCH-deep delay so rgb_de trails req; flushed while disabled
    if (PREFETCH == 0) begin : g_no_dly
        assign out_vec = s1_vec;
    end else begin : g_dly
        logic [TAP_W-1:0] dly [PREFETCH];

        always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
            if (!rgb_rst_n) begin
                for (int unsigned i = 0; i < PREFETCH; i++) dly[i] <= '0;
            end else if (!en) begin
                for (int unsigned i = 0; i < PREFETCH; i++) dly[i] <= '0;
            end else begin
                dly[0] <= s1_vec;
                for (int unsigned i = 1; i < PREFETCH; i++) dly[i] <= dly[i-1];
            end
        end

        assign out_vec = dly[PREFETCH-1];
    end

    assign {out_hs, out_vs, rgb_de, frame_start, line_start, rgb_x, rgb_y} = out_vec;
    assign rgb_hs = out_hs ? HS_POL : ~HS_POL;
    assign rgb_vs = out_vs ? VS_POL : ~VS_POL;

endmodule

// File: tb/tb_rgb_timing_gen.sv
// Bench for rgb_timing_gen: frame-position model checked every cycle plus
// directed scenarios with hand-computed periods, offsets and counts.
module tb_rgb_timing_gen;

    localparam int P = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, cfg_wr;
    logic [11:0] c_ha, c_hf, c_hs, c_hb, c_va, c_vf, c_vs, c_vb;
    logic        cfg_pending, cfg_err, req, rgb_hs, rgb_vs, rgb_de, frame_start, line_start;
    logic [10:0] req_x, req_y, rgb_x, rgb_y;

    rgb_timing_gen #(.PREFETCH(P)) dut (
        .rgb_clk(clk), .rgb_rst_n(rst_n), .en(en), .cfg_wr(cfg_wr),
        .cfg_h_active(c_ha), .cfg_h_fp(c_hf), .cfg_h_sync(c_hs), .cfg_h_bp(c_hb),
        .cfg_v_active(c_va), .cfg_v_fp(c_vf), .cfg_v_sync(c_vs), .cfg_v_bp(c_vb),
        .cfg_pending(cfg_pending), .cfg_err(cfg_err),
        .req(req), .req_x(req_x), .req_y(req_y),
        .rgb_hs(rgb_hs), .rgb_vs(rgb_vs), .rgb_de(rgb_de),
        .rgb_x(rgb_x), .rgb_y(rgb_y),
        .frame_start(frame_start), .line_start(line_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Model: timing as integers, frame position as a flat pixel index
    typedef struct packed {
        logic hs, vs, de, fs, ls;
        logic [10:0] x, y;
    } ent_t;

    int   tm[8];
    int   sh[8];
    int   m_p, m_n, last_low;
    bit   m_pend, m_err;
    ent_t hist[16];

    function automatic bit cfg_valid(input int c[8]);
        return c[0] != 0 && c[2] != 0 && c[4] != 0 && c[6] != 0
               && (c[0] + c[1] + c[2] + c[3]) <= 4095 && (c[4] + c[5] + c[6] + c[7]) <= 4095;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            tm = '{480, 2, 41, 2, 272, 2, 10, 2};
            sh = '{0, 0, 0, 0, 0, 0, 0, 0};
            m_pend = 1'b0; m_err = 1'b0;
            m_p = 0; m_n = 0; last_low = 0;
            for (int i = 0; i < 16; i++) hist[i] = '0;
        end else begin
            int ht, vt, h, v, xs, ys, frame_len;
            int c[8];
            ent_t e;
            c = '{int'(c_ha), int'(c_hf), int'(c_hs), int'(c_hb),
                  int'(c_va), int'(c_vf), int'(c_vs), int'(c_vb)};
            ht = tm[0] + tm[1] + tm[2] + tm[3];
            vt = tm[4] + tm[5] + tm[6] + tm[7];
            frame_len = ht * vt;
            h  = m_p % ht;
            v  = m_p / ht;
            xs = tm[2] + tm[3];
            ys = tm[6] + tm[7];
            e  = '0;
            if (en) begin
                e.hs = h < tm[2];
                e.vs = v < tm[6];
                e.de = h >= xs && h < xs + tm[0] && v >= ys && v < ys + tm[4];
                if (e.de) begin
                    e.x = 11'(h - xs);
                    e.y = 11'(v - ys);
                end
                e.fs = m_p == 0;
                e.ls = h == 0;
            end
            m_n++;
            hist[m_n % 16] = e;
            if (!en) last_low = m_n;
            m_err = cfg_wr && !cfg_valid(c);
            if (m_pend && (!en || m_p == frame_len - 1)) begin
                tm = sh;
                m_pend = 1'b0;
            end
            if (cfg_wr && cfg_valid(c)) begin
                sh = c;
                m_pend = 1'b1;
            end
            m_p = (!en || m_p == frame_len - 1) ? 0 : m_p + 1;
        end
    end

    // Every-cycle comparison against the model
    initial forever begin
        ent_t er, eo;
        @(negedge clk);
        if (rst_n) begin
            er = hist[m_n % 16];
            eo = '0;
            if (m_n - P >= 0 && !(last_low > m_n - P)) eo = hist[(m_n - P) % 16];
            check("req", req, er.de);
            check("req_x", req_x, er.x);
            check("req_y", req_y, er.y);
            check("rgb_hs", rgb_hs, !eo.hs);
            check("rgb_vs", rgb_vs, !eo.vs);
            check("rgb_de", rgb_de, eo.de);
            check("rgb_x", rgb_x, eo.x);
            check("rgb_y", rgb_y, eo.y);
            check("frame_start", frame_start, eo.fs);
            check("line_start", line_start, eo.ls);
            check("cfg_pending", cfg_pending, m_pend);
            check("cfg_err", cfg_err, m_err);
        end
    end

    task automatic wait_fs(output int stamp);
        stamp = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                stamp = cyc;
                return;
            end
        end
        check("frame_start_timeout", 0, 1);
    endtask

    task automatic wait_ls(output int stamp);
        stamp = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (line_start === 1'b1) begin
                stamp = cyc;
                return;
            end
        end
        check("line_start_timeout", 0, 1);
    endtask

    task automatic set_cfg(input int ha, input int hf, input int hs, input int hb,
                           input int va, input int vf, input int vs, input int vb);
        c_ha = 12'(ha); c_hf = 12'(hf); c_hs = 12'(hs); c_hb = 12'(hb);
        c_va = 12'(va); c_vf = 12'(vf); c_vs = 12'(vs); c_vb = 12'(vb);
    endtask

    initial begin
        int a, b, c, d, e, f, g, h;
        int de_cnt, hs_low, vs_low, ls_cnt, x_max, y_max, first_de, first_req;
        bit found;
        rst_n = 1'b0; en = 1'b0; cfg_wr = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_hs", rgb_hs, 1);
        check("rst_vs", rgb_vs, 1);
        check("rst_de", rgb_de, 0);
        check("rst_req", req, 0);
        check("rst_pending", cfg_pending, 0);
        check("rst_fs", frame_start, 0);
        rst_n = 1'b1;

        // Small timing applied from idle
        @(negedge clk);
        set_cfg(8, 1, 2, 1, 4, 1, 1, 1);
        cfg_wr = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0;
        check("idle_pending_set", cfg_pending, 1);
        @(negedge clk);
        check("idle_pending_applied", cfg_pending, 0);
        en = 1'b1;

        wait_fs(a);
        de_cnt = 0; hs_low = 0; vs_low = 0; ls_cnt = 0; x_max = 0; y_max = 0;
        first_de = -1; first_req = -1;
        for (int i = 0; i < 84; i++) begin
            if (rgb_de) begin
                de_cnt++;
                if (first_de < 0) first_de = i;
                if (int'(rgb_x) > x_max) x_max = int'(rgb_x);
                if (int'(rgb_y) > y_max) y_max = int'(rgb_y);
            end
            if (req && first_req < 0) first_req = i;
            if (!rgb_hs) hs_low++;
            if (!rgb_vs) vs_low++;
            if (line_start) ls_cnt++;
            @(negedge clk);
        end
        check("fs_period_84", frame_start, 1);
        check("de_per_frame", de_cnt, 32);
        check("hs_low_per_frame", hs_low, 14);
        check("vs_low_per_frame", vs_low, 12);
        check("lines_per_frame", ls_cnt, 7);
        check("first_de_offset", first_de, 27);
        check("first_req_offset", first_req, 25);
        check("x_max", x_max, 7);
        check("y_max", y_max, 3);

        // Mid-frame reconfiguration to 10 active pixels per line
        b = cyc;
        repeat (30) @(negedge clk);
        set_cfg(10, 1, 2, 1, 4, 1, 1, 1);
        cfg_wr = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0;
        check("midframe_pending", cfg_pending, 1);
        wait_fs(c);
        check("old_frame_period", c - b, 84);
        check("pending_cleared", cfg_pending, 0);
        wait_fs(d);
        check("new_frame_period", d - c, 98);

        // Rejected write: zero sync width
        repeat (10) @(negedge clk);
        set_cfg(10, 1, 0, 1, 4, 1, 1, 1);
        cfg_wr = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0;
        check("cfg_err_pulse", cfg_err, 1);
        @(negedge clk);
        check("cfg_err_single", cfg_err, 0);
        check("reject_no_pending", cfg_pending, 0);
        wait_fs(e);
        wait_fs(f);
        check("period_after_reject", f - e, 98);

        // Enable dropped for 5 cycles in the middle of an active line
        repeat (40) @(negedge clk);
        check("de_before_drop", rgb_de, 1);
        en = 1'b0;
        @(negedge clk);
        check("drop_de", rgb_de, 0);
        check("drop_req", req, 0);
        check("drop_hs", rgb_hs, 1);
        repeat (4) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check("fs_rise_1", frame_start, 0);
        @(negedge clk);
        check("fs_rise_2", frame_start, 0);
        @(negedge clk);
        check("fs_rise_3", frame_start, 1);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (rgb_de) found = 1'b1;
        end
        check("reenable_de_seen", found, 1);
        check("reenable_y0", rgb_y, 0);
        check("reenable_x0", rgb_x, 0);

        // Async reset while de is high
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_de", rgb_de, 0);
        check("async_rst_hs", rgb_hs, 1);
        check("async_rst_vs", rgb_vs, 1);
        check("async_rst_req", req, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ls(g);
        wait_ls(h);
        check("default_line_period", h - g, 525);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/rgb_timing_gen.md
Name: rgb_timing_gen

Overview:
Parametrised, runtime-reconfigurable RGB/LCD video timing generator, successor to the fixed 480x272 timing block. It produces HS, VS, DE, pixel coordinates and frame/line strobes for parallel-RGB panels. It also provides a pixel-request channel that leads DE by a configurable number of cycles, so upstream frame-buffer/pattern logic with fixed read latency stays aligned. Timing can be changed while running through a shadow-register handshake; changes apply only at frame boundaries.

Parameters:
CNT_W, 12, width of h/v counters and timing fields
XY_W, 11, width of coordinate outputs
PREFETCH, 2, cycles req leads de (0..7)
HS_POL, 0, active level of rgb_hs
VS_POL, 0, active level of rgb_vs
DEF_H_ACTIVE, 480, reset horizontal active pixels
DEF_H_FP, 2, reset horizontal front porch
DEF_H_SYNC, 41, reset horizontal sync width
DEF_H_BP, 2, reset horizontal back porch
DEF_V_ACTIVE, 272, reset vertical active lines
DEF_V_FP, 2, reset vertical front porch
DEF_V_SYNC, 10, reset vertical sync width
DEF_V_BP, 2, reset vertical back porch

Ports:
rgb_clk  in  1  pixel clock; single clock domain
rgb_rst_n  in  1  asynchronous, active-low reset
en  in  1  timing enable; low = idle, counters held at 0
cfg_wr  in  1  one-cycle strobe: capture cfg_* fields
cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  CNT_W each  new horizontal timing
cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  CNT_W each  new vertical timing
cfg_pending  out  1  captured config waiting for frame boundary
cfg_err  out  1  one-cycle pulse: write rejected
req  out  1  pixel request, PREFETCH cycles ahead of de
req_x, req_y  out  XY_W each  coordinate of requested pixel
rgb_hs, rgb_vs, rgb_de  out  1 each  panel sync and data enable
rgb_x, rgb_y  out  XY_W each  coordinate of the pixel currently under de
frame_start  out  1  pulse aligned with first cycle of frame (h=0,v=0)
line_start  out  1  pulse aligned with h=0 of every line

Behaviour:
- Reset: h/v counters 0; active timing = DEF_*; shadow empty; cfg_pending=0, cfg_err=0, req=0, req_x=req_y=0, rgb_de=0, rgb_x=rgb_y=0, rgb_hs=~HS_POL, rgb_vs=~VS_POL, frame_start=line_start=0; delay line cleared.
- Line order: SYNC, BP, ACTIVE, FP. H_TOTAL = sum of h fields; V_TOTAL likewise. h_cnt wraps at H_TOTAL-1; v_cnt increments when h_cnt wraps and wraps at V_TOTAL-1.
- Stage 1 (registered, 1 cycle after counter): req = (h_cnt in active) & (v_cnt in active). req_x = h_cnt-(H_SYNC+H_BP), req_y = v_cnt-(V_SYNC+V_BP), both truncated to XY_W, and 0 when req=0. Also decodes hs/vs active (h_cnt<H_SYNC, v_cnt<V_SYNC), frame_start and line_start.
- Stage 2: hs, vs, de, x, y, frame_start and line_start pass through a PREFETCH-deep register delay. rgb_* therefore lag the counter by PREFETCH+1 cycles, and req leads rgb_de by exactly PREFETCH cycles. PREFETCH=0 gives no delay line.
- rgb_hs = HS_POL while hs active, else ~HS_POL; VS likewise.
- Config: on cfg_wr, validate. Reject if any active or sync field is 0, or if the h or v sum overflows CNT_W. On rejection, pulse cfg_err the next cycle; the shadow is unchanged.
- A valid write loads the shadow and sets cfg_pending. A write while pending overwrites the shadow.
- Apply: shadow is copied to the active timing, and cfg_pending clears, on the cycle the counter is at (H_TOTAL-1, V_TOTAL-1). The next frame uses the new timing from count (0,0). If cfg_wr coincides with the apply cycle, the old shadow is applied and the new write becomes pending.
- en low: counters forced to (0,0) every cycle; stage-1 outputs inactive; delay line flushed synchronously (outputs inactive next cycle). Any pending config applies immediately.
- en rise: frame begins at counter (0,0); frame_start appears PREFETCH+1 cycles later.
- Async reset mid-frame returns all state to reset values immediately. Shadow contents are lost.

Test Plan:
- Reset, en=1, PREFETCH=2, cfg H 8/1/2/1 (active/fp/sync/bp), V 4/1/1/1 applied from idle -> H_TOTAL 12, frame period 84 cycles. Per line: rgb_hs low 2 cycles, de high 8 cycles with rgb_x 0..7. rgb_y 0..3 across lines 2..5. rgb_vs low exactly line 0.
- Same config -> req rises exactly 2 cycles before rgb_de. req_x sequence equals rgb_x sequence shifted 2 cycles. Both coordinates are 0 outside the active region.
- Mid-frame valid cfg_wr (H active 10) -> cfg_pending=1 until the last cycle of the frame. Current frame keeps 12-cycle lines; the next frame has 14-cycle lines. frame_start period is 84, then 98.
- cfg_wr with cfg_h_sync=0 -> cfg_err pulses one cycle, cfg_pending unchanged, timing unchanged.
- Drop en for 5 cycles mid-line -> outputs inactive from the next cycle. On re-enable, frame_start fires 3 cycles after en rise and rgb_y restarts at 0.
- Assert rgb_rst_n low mid-active -> rgb_de=0, rgb_hs=rgb_vs=1 (POL=0) asynchronously. Timing reverts to DEF_* (H_TOTAL 525, V_TOTAL 286).
